// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Number of address bits needed to index n registers (n a power of two).
  function automatic int addr_w(input int n);
    int w;
    w = 0;
    for (int k = 0; k < 31; k++) begin
      if ((32'sd1 <<< k) < n) begin
        w = k + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: set/clear/flush priority, busy count and protocol-error pulse.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int   NREGS = NREGS_DEF,
  localparam int  AW    = addr_w(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wp0_en,
  input  logic [AW-1:0]    wp0_addr,
  input  logic             wp1_en,
  input  logic [AW-1:0]    wp1_addr,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic             sb_err,
  output logic [AW:0]      busy_cnt
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             err_q;
  logic             err_d;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic             set_ok_s;
  logic             clr_ok_s;
  logic             waw_s;
  logic             dbl_set_s;
  logic             stray_clr_s;

  // Qualify requests: x0 is never tracked, and flush suppresses a new mark.
  always_comb begin
    set_ok_s    = sb_set && (sb_addr != {AW{1'b0}}) && !flush;
    clr_ok_s    = wp1_en && (wp1_addr != {AW{1'b0}});
    waw_s       = wp0_en && clr_ok_s && (wp0_addr == wp1_addr);
    dbl_set_s   = set_ok_s && busy_q[sb_addr];
    stray_clr_s = clr_ok_s && !busy_q[wp1_addr];
    err_d       = waw_s || dbl_set_s || stray_clr_s;
  end

  // Next busy vector: flush clears all, otherwise clear then set so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = {NREGS{1'b0}};
    end else begin
      if (clr_ok_s) begin
        busy_d[wp1_addr] = 1'b0;
      end else begin
        busy_d = busy_d;
      end
      if (set_ok_s) begin
        busy_d[sb_addr] = 1'b1;
      end else begin
        busy_d = busy_d;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Population count of the post-edge busy vector.
  always_comb begin
    cnt_d = {(AW+1){1'b0}};
    for (int k = 0; k < NREGS; k++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[k]};
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= {NREGS{1'b0}};
      err_q  <= 1'b0;
      cnt_q  <= {(AW+1){1'b0}};
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign sb_err   = err_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write bypass and long-latency busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  XLEN  = XLEN_DEF,
  parameter int  NREGS = NREGS_DEF,
  parameter int  NRP   = 2,
  localparam int AW    = addr_w(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRP*AW-1:0] rs_addr,
  output logic [NRP*XLEN-1:0] rs_data,
  output logic [NRP-1:0]    rs_busy,
  input  logic              wp0_en,
  input  logic [AW-1:0]     wp0_addr,
  input  logic [XLEN-1:0]   wp0_data,
  input  logic              wp1_en,
  input  logic [AW-1:0]     wp1_addr,
  input  logic [XLEN-1:0]   wp1_data,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  input  logic              flush,
  output logic              sb_err,
  output logic [AW:0]       busy_cnt,
  input  logic [AW-1:0]     dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_s;
  logic [AW-1:0]    rd_addr_s [NRP];
  logic             wp0_hit_s;
  logic             wp1_hit_s;

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wp0_en   (wp0_en),
    .wp0_addr (wp0_addr),
    .wp1_en   (wp1_en),
    .wp1_addr (wp1_addr),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .flush    (flush),
    .busy     (busy_s),
    .sb_err   (sb_err),
    .busy_cnt (busy_cnt)
  );

  // Register storage; x0 is never written so it stays zero, wp0 beats wp1 on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= {XLEN{1'b0}};
      end
    end else begin
      for (int k = 1; k < NREGS; k++) begin
        if (wp0_en && (wp0_addr == AW'(k))) begin
          regs_q[k] <= wp0_data;
        end else if (wp1_en && (wp1_addr == AW'(k))) begin
          regs_q[k] <= wp1_data;
        end else begin
          regs_q[k] <= regs_q[k];
        end
      end
    end
  end

  // Read ports: x0 reads zero, same-cycle writes are forwarded, completing results read not busy.
  always_comb begin
    rs_data   = {(NRP*XLEN){1'b0}};
    rs_busy   = {NRP{1'b0}};
    wp0_hit_s = 1'b0;
    wp1_hit_s = 1'b0;
    for (int i = 0; i < NRP; i++) begin
      rd_addr_s[i] = rs_addr[i*AW +: AW];
      wp0_hit_s    = wp0_en && (wp0_addr == rd_addr_s[i]);
      wp1_hit_s    = wp1_en && (wp1_addr == rd_addr_s[i]);
      if (rd_addr_s[i] == {AW{1'b0}}) begin
        rs_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
      end else if (wp0_hit_s) begin
        rs_data[i*XLEN +: XLEN] = wp0_data;
      end else if (wp1_hit_s) begin
        rs_data[i*XLEN +: XLEN] = wp1_data;
      end else begin
        rs_data[i*XLEN +: XLEN] = regs_q[rd_addr_s[i]];
      end
      rs_busy[i] = busy_s[rd_addr_s[i]] && !wp1_hit_s;
    end
  end

  // Debug port shows stored state only, never forwarded data.
  always_comb begin
    dbg_data = regs_q[dbg_addr];
  end

endmodule
